l2_adder_sched: RTL

- Round-robin scheduler that shares one Lab2 ASCII adder/subtractor between two requesters, e.g. the console command path and the LED self-test path.
- Accepts an operation from a requester, latches the operands and drives the adder's start/subtract/r1/r2 inputs.
- Waits for the adder's ready pulse, then returns the 8-bit ASCII result to the granted requester.
- A watchdog converts a missing ready pulse into an error completion, so a requester is never stranded.

---
 rtl/l2_adder_sched_if.sv | 54 +++++
 rtl/l2_adder_sched.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/l2_adder_sched_if.sv
// l2_adder_sched_if
// Bundles every signal of the adder scheduler apart from clock and reset:
// the two requester handshakes, the shared response bus, and the
// connection to the Lab2 ASCII adder/subtractor.
//   slave  : scheduler side (takes requests and adder results, drives
//            acks, dones, response and adder controls)
//   master : environment side (requesters plus the adder)
interface l2_adder_sched_if;
    logic       req0_valid;
    logic       req0_sub;
    logic [7:0] req0_r1;
    logic [7:0] req0_r2;
    logic       req0_ack;
    logic       req0_done;

    logic       req1_valid;
    logic       req1_sub;
    logic [7:0] req1_r1;
    logic [7:0] req1_r2;
    logic       req1_ack;
    logic       req1_done;

    logic [7:0] rsp_data;
    logic       rsp_err;

    logic       adder_start;
    logic       adder_subtract;
    logic [7:0] adder_r1;
    logic [7:0] adder_r2;
    logic [7:0] adder_data;
    logic       adder_rdy;

    logic       busy;

    modport slave (
        input  req0_valid, req0_sub, req0_r1, req0_r2,
        input  req1_valid, req1_sub, req1_r1, req1_r2,
        input  adder_data, adder_rdy,
        output req0_ack, req0_done, req1_ack, req1_done,
        output rsp_data, rsp_err,
        output adder_start, adder_subtract, adder_r1, adder_r2,
        output busy
    );

    modport master (
        output req0_valid, req0_sub, req0_r1, req0_r2,
        output req1_valid, req1_sub, req1_r1, req1_r2,
        output adder_data, adder_rdy,
        input  req0_ack, req0_done, req1_ack, req1_done,
        input  rsp_data, rsp_err,
        input  adder_start, adder_subtract, adder_r1, adder_r2,
        input  busy
    );
endinterface

// File: rtl/l2_adder_sched.sv
// l2_adder_sched
// Round-robin scheduler sharing one Lab2 ASCII adder/subtractor between two
// requesters. Latches the granted operation, starts the adder, waits for
// its ready pulse (or a watchdog timeout) and returns the result to the
// granted requester. All outputs are registered.
// Ports:
//   clk      : clock, all state on the rising edge
//   Gl_rst_n : asynchronous active-low reset
//   bus      : l2_adder_sched_if.slave (requester handshakes, response,
//              adder controls/results, busy)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no operation in flight; arbitrate and grant
// S_ISSUE | adder_start and ack of the granted requester high; clear watchdog
// S_WAIT  | operands held; wait for adder_rdy or watchdog timeout
// S_DONE  | done pulse of the granted requester; response stable
module l2_adder_sched #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              Gl_rst_n,
    l2_adder_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WD_ONE   = CNT_W'(1);
    localparam logic [7:0]       ERR_CHAR = 8'h3F;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             last_q, last_d;
    logic             gnt_q, gnt_d;
    logic             start_q, start_d;
    logic             sub_q, sub_d;
    logic [7:0]       r1_q, r1_d;
    logic [7:0]       r2_q, r2_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [7:0]       rsp_q, rsp_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             gnt_sel;
    logic             finish;

    always_ff @(posedge clk or negedge Gl_rst_n) begin
        if (!Gl_rst_n) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
            last_q  <= 1'b1;   // requester 0 wins the first contention
            gnt_q   <= 1'b0;
            start_q <= 1'b0;
            sub_q   <= 1'b0;
            r1_q    <= 8'h00;
            r2_q    <= 8'h00;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rsp_q   <= 8'h00;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            sub_q   <= sub_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Outputs are computed one cycle ahead so that they are registered and
    // line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        start_d = 1'b0;
        sub_d   = sub_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        rsp_d   = rsp_q;
        err_d   = err_q;
        busy_d  = busy_q;
        gnt_sel = 1'b0;
        finish  = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.req0_valid || bus.req1_valid) begin
                    // Under contention alternate away from the last grant.
                    if (bus.req0_valid && bus.req1_valid) gnt_sel = ~last_q;
                    else                                  gnt_sel = bus.req1_valid;
                    gnt_d   = gnt_sel;
                    last_d  = gnt_sel;
                    sub_d   = gnt_sel ? bus.req1_sub : bus.req0_sub;
                    r1_d    = gnt_sel ? bus.req1_r1  : bus.req0_r1;
                    r2_d    = gnt_sel ? bus.req1_r2  : bus.req0_r2;
                    start_d = 1'b1;
                    ack0_d  = ~gnt_sel;
                    ack1_d  = gnt_sel;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A ready pulse in the timeout cycle still counts as success.
                if (bus.adder_rdy) begin
                    rsp_d  = bus.adder_data;
                    err_d  = 1'b0;
                    finish = 1'b1;
                end else if (wd_q == WD_LIMIT) begin
                    rsp_d  = ERR_CHAR;
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
                if (finish) begin
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                    sub_d   = 1'b0;
                    r1_d    = 8'h00;
                    r2_d    = 8'h00;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.req0_ack       = ack0_q;
    assign bus.req1_ack       = ack1_q;
    assign bus.req0_done      = done0_q;
    assign bus.req1_done      = done1_q;
    assign bus.rsp_data       = rsp_q;
    assign bus.rsp_err        = err_q;
    assign bus.adder_start    = start_q;
    assign bus.adder_subtract = sub_q;
    assign bus.adder_r1       = r1_q;
    assign bus.adder_r2       = r2_q;
    assign bus.busy           = busy_q;

endmodule
